// File: rtl/dispatch_credit_ctrl.sv
// Dispatch admission against registered IQ/LDQ/STQ/AL free-entry credits; stall is combinational from held counts.
// Zero-latency decision, one-cycle credit return; a stalled bundle is held upstream and re-evaluated each cycle.

module dispatch_credit_ctr #(
  parameter int SIZE    = 32,
  parameter int CNT_W   = 6,
  parameter int NEED_W  = 3,
  parameter int FREED_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               fire,
  input  logic [NEED_W-1:0]  need,
  input  logic [FREED_W-1:0] freed,
  output logic [CNT_W-1:0]   free,
  output logic               insufficient
);
  localparam int EXT_W = CNT_W + 1;
  localparam logic [EXT_W-1:0] SIZE_EXT = EXT_W'(SIZE);
  localparam logic [CNT_W-1:0] SIZE_CNT = CNT_W'(SIZE);

  logic [EXT_W-1:0] need_ext;
  logic [EXT_W-1:0] freed_ext;
  logic [EXT_W-1:0] free_ext;
  logic [EXT_W-1:0] sum;
  logic [CNT_W-1:0] free_nxt;

  assign need_ext     = EXT_W'(need);
  assign freed_ext    = EXT_W'(freed);
  assign free_ext     = EXT_W'(free);
  assign insufficient = need_ext > free_ext;

  // One extra bit lets an over-return be detected and clamped rather than wrapping.
  always_comb begin
    sum      = free_ext - (fire ? need_ext : '0) + freed_ext;
    free_nxt = (sum > SIZE_EXT) ? SIZE_CNT : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      free <= SIZE_CNT;
    end else begin
      free <= free_nxt;
    end
  end
endmodule

module dispatch_credit_ctrl #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int COMMIT_WIDTH   = 4,
  parameter int ISSUE_WIDTH    = 4,
  parameter int IQ_SIZE        = 32,
  parameter int LDQ_SIZE       = 16,
  parameter int STQ_SIZE       = 16,
  parameter int AL_SIZE        = 128
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush_i,
  input  logic [DISPATCH_WIDTH-1:0]         laneActive_i,
  input  logic                              bundleValid_i,
  input  logic [DISPATCH_WIDTH-1:0]         isLoad_i,
  input  logic [DISPATCH_WIDTH-1:0]         isStore_i,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]  iqFreed_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] ldqFreed_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] stqFreed_i,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] alFreed_i,
  output logic                              stall_o,
  output logic                              dispatchFire_o,
  output logic [3:0]                        stallReason_o,
  output logic [$clog2(IQ_SIZE+1)-1:0]      iqFree_o,
  output logic [$clog2(LDQ_SIZE+1)-1:0]     ldqFree_o,
  output logic [$clog2(STQ_SIZE+1)-1:0]     stqFree_o,
  output logic [$clog2(AL_SIZE+1)-1:0]      alFree_o,
  output logic [31:0]                       stallCycles_o
);
  localparam int NW  = $clog2(DISPATCH_WIDTH + 1);
  localparam int IFW = $clog2(ISSUE_WIDTH + 1);
  localparam int CFW = $clog2(COMMIT_WIDTH + 1);

  function automatic logic [NW-1:0] popcount(input logic [DISPATCH_WIDTH-1:0] v);
    logic [NW-1:0] c;
    c = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      c = c + NW'(v[i]);
    end
    return c;
  endfunction

  logic [NW-1:0] need_lanes;
  logic [NW-1:0] need_ld;
  logic [NW-1:0] need_st;
  logic          iq_short;
  logic          ldq_short;
  logic          stq_short;
  logic          al_short;
  logic          any_short;

  assign need_lanes = popcount(laneActive_i);
  assign need_ld    = popcount(isLoad_i & laneActive_i);
  assign need_st    = popcount(isStore_i & laneActive_i);

  assign stallReason_o  = {al_short, stq_short, ldq_short, iq_short} & {4{bundleValid_i}};
  assign any_short      = |stallReason_o;
  assign stall_o        = any_short & ~flush_i;
  assign dispatchFire_o = bundleValid_i & ~any_short & ~flush_i;

  dispatch_credit_ctr #(
    .SIZE(IQ_SIZE), .CNT_W($clog2(IQ_SIZE+1)), .NEED_W(NW), .FREED_W(IFW)
  ) u_iq (
    .clk(clk), .reset(reset), .flush(flush_i), .fire(dispatchFire_o),
    .need(need_lanes), .freed(iqFreed_i), .free(iqFree_o), .insufficient(iq_short)
  );

  dispatch_credit_ctr #(
    .SIZE(LDQ_SIZE), .CNT_W($clog2(LDQ_SIZE+1)), .NEED_W(NW), .FREED_W(CFW)
  ) u_ldq (
    .clk(clk), .reset(reset), .flush(flush_i), .fire(dispatchFire_o),
    .need(need_ld), .freed(ldqFreed_i), .free(ldqFree_o), .insufficient(ldq_short)
  );

  dispatch_credit_ctr #(
    .SIZE(STQ_SIZE), .CNT_W($clog2(STQ_SIZE+1)), .NEED_W(NW), .FREED_W(CFW)
  ) u_stq (
    .clk(clk), .reset(reset), .flush(flush_i), .fire(dispatchFire_o),
    .need(need_st), .freed(stqFreed_i), .free(stqFree_o), .insufficient(stq_short)
  );

  dispatch_credit_ctr #(
    .SIZE(AL_SIZE), .CNT_W($clog2(AL_SIZE+1)), .NEED_W(NW), .FREED_W(CFW)
  ) u_al (
    .clk(clk), .reset(reset), .flush(flush_i), .fire(dispatchFire_o),
    .need(need_lanes), .freed(alFreed_i), .free(alFree_o), .insufficient(al_short)
  );

  // Survives flush so recovery-heavy phases still show up in the stall statistic.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCycles_o <= '0;
    end else if (stall_o && (stallCycles_o != 32'hFFFF_FFFF)) begin
      stallCycles_o <= stallCycles_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Directed bench for dispatch_credit_ctrl: per-cycle credit model plus hand-computed pins.
module tb_dispatch_credit_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic [3:0]  laneActive_i = '0;
  logic        bundleValid_i = 1'b0;
  logic [3:0]  isLoad_i = '0;
  logic [3:0]  isStore_i = '0;
  logic [2:0]  iqFreed_i = '0;
  logic [2:0]  ldqFreed_i = '0;
  logic [2:0]  stqFreed_i = '0;
  logic [2:0]  alFreed_i = '0;
  logic        stall_o;
  logic        dispatchFire_o;
  logic [3:0]  stallReason_o;
  logic [5:0]  iqFree_o;
  logic [4:0]  ldqFree_o;
  logic [4:0]  stqFree_o;
  logic [7:0]  alFree_o;
  logic [31:0] stallCycles_o;

  dispatch_credit_ctrl dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .laneActive_i(laneActive_i),
    .bundleValid_i(bundleValid_i), .isLoad_i(isLoad_i), .isStore_i(isStore_i),
    .iqFreed_i(iqFreed_i), .ldqFreed_i(ldqFreed_i), .stqFreed_i(stqFreed_i),
    .alFreed_i(alFreed_i), .stall_o(stall_o), .dispatchFire_o(dispatchFire_o),
    .stallReason_o(stallReason_o), .iqFree_o(iqFree_o), .ldqFree_o(ldqFree_o),
    .stqFree_o(stqFree_o), .alFree_o(alFree_o), .stallCycles_o(stallCycles_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_proto = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  function automatic int cap(input int k);
    case (k)
      0: return 32;
      1: return 16;
      2: return 16;
      default: return 128;
    endcase
  endfunction

  function automatic int dut_free(input int k);
    case (k)
      0: return int'(iqFree_o);
      1: return int'(ldqFree_o);
      2: return int'(stqFree_o);
      default: return int'(alFree_o);
    endcase
  endfunction

  // Model state: free credits per queue (0=IQ,1=LDQ,2=STQ,3=AL) and stall counter.
  int     m_free[4] = '{32, 16, 16, 128};
  longint m_sc = 0;

  always @(negedge clk) begin
    int need[4];
    int freed[4];
    int nl;
    int nld;
    int nst;
    int v;
    logic [3:0] e_reason;
    logic e_stall;
    logic e_fire;
    nl = 0; nld = 0; nst = 0;
    for (int i = 0; i < 4; i++) begin
      if (laneActive_i[i]) begin
        nl++;
        if (isLoad_i[i]) nld++;
        if (isStore_i[i]) nst++;
      end
    end
    need[0] = nl; need[1] = nld; need[2] = nst; need[3] = nl;
    freed[0] = int'(iqFreed_i); freed[1] = int'(ldqFreed_i);
    freed[2] = int'(stqFreed_i); freed[3] = int'(alFreed_i);
    for (int k = 0; k < 4; k++) e_reason[k] = bundleValid_i && (need[k] > m_free[k]);
    e_stall = (e_reason != 4'b0) && !flush_i;
    e_fire  = bundleValid_i && (e_reason == 4'b0) && !flush_i;
    if (chk_en) begin
      chk("model_stall", {31'b0, stall_o}, {31'b0, e_stall});
      chk("model_fire", {31'b0, dispatchFire_o}, {31'b0, e_fire});
      chk("model_reason", {28'b0, stallReason_o}, {28'b0, e_reason});
      for (int k = 0; k < 4; k++) chk($sformatf("model_free%0d", k), 32'(dut_free(k)), 32'(m_free[k]));
      chk("model_stallcycles", stallCycles_o, m_sc[31:0]);
    end
    if (reset) begin
      for (int k = 0; k < 4; k++) m_free[k] = cap(k);
      m_sc = 0;
    end else if (flush_i) begin
      for (int k = 0; k < 4; k++) m_free[k] = cap(k);
    end else begin
      for (int k = 0; k < 4; k++) begin
        v = m_free[k] - (e_fire ? need[k] : 0) + freed[k];
        if (v > cap(k)) begin
          n_proto++;
          $display("note: credit over-return on queue %0d (%0d > %0d), clamped", k, v, cap(k));
          v = cap(k);
        end
        m_free[k] = v;
      end
      if (e_stall && m_sc < 64'hFFFF_FFFF) m_sc++;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state with no bundle.
    at_mid();
    chk("rst_iq", 32'(iqFree_o), 32);
    chk("rst_ldq", 32'(ldqFree_o), 16);
    chk("rst_stq", 32'(stqFree_o), 16);
    chk("rst_al", 32'(alFree_o), 128);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_sc", stallCycles_o, 0);
    next_cyc();

    // Drain the issue queue with full bundles.
    bundleValid_i = 1'b1; laneActive_i = 4'hF;
    for (int k = 0; k < 8; k++) begin
      at_mid();
      chk("drain_iq", 32'(iqFree_o), 32'(32 - 4 * k));
      chk("drain_fire", 32'(dispatchFire_o), 1);
      next_cyc();
    end
    at_mid();
    chk("iq_empty_stall", 32'(stall_o), 1);
    chk("iq_empty_reason", 32'(stallReason_o), 32'b0001);
    chk("iq_empty_al", 32'(alFree_o), 96);
    next_cyc();
    next_cyc();
    iqFreed_i = 3'd4;
    at_mid();
    chk("no_bypass_stall", 32'(stall_o), 1);
    next_cyc();
    iqFreed_i = 3'd0;
    at_mid();
    chk("refill_fire", 32'(dispatchFire_o), 1);
    chk("refill_iq", 32'(iqFree_o), 4);
    chk("refill_sc", stallCycles_o, 3);
    next_cyc();
    bundleValid_i = 1'b0;
    at_mid();
    chk("after_fire_iq", 32'(iqFree_o), 0);
    chk("idle_reason", 32'(stallReason_o), 0);
    chk("idle_stall", 32'(stall_o), 0);
    chk("after_fire_sc", stallCycles_o, 3);
    chk("after_fire_al", 32'(alFree_o), 92);
    next_cyc();

    // Load-queue exhaustion with two-lane bundles.
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    bundleValid_i = 1'b1; laneActive_i = 4'b0011; isLoad_i = 4'hF; isStore_i = 4'h0;
    repeat (8) next_cyc();
    at_mid();
    chk("ldq_stall", 32'(stall_o), 1);
    chk("ldq_reason", 32'(stallReason_o), 32'b0010);
    chk("ldq_iq", 32'(iqFree_o), 16);
    chk("ldq_empty", 32'(ldqFree_o), 0);
    next_cyc();
    bundleValid_i = 1'b0; ldqFreed_i = 3'd4;
    next_cyc();
    ldqFreed_i = 3'd0;
    bundleValid_i = 1'b1; laneActive_i = 4'hF; isLoad_i = 4'h0; isStore_i = 4'hF;
    at_mid();
    chk("st_fire", 32'(dispatchFire_o), 1);
    next_cyc();
    isLoad_i = 4'hF; isStore_i = 4'h0;
    at_mid();
    chk("ld_fire", 32'(dispatchFire_o), 1);
    next_cyc();
    at_mid();
    chk("ld_restall_reason", 32'(stallReason_o), 32'b0010);
    chk("ld_restall_stq", 32'(stqFree_o), 12);
    next_cyc();

    // Flush with a stalled bundle and nonzero frees.
    flush_i = 1'b1; iqFreed_i = 3'd3; ldqFreed_i = 3'd2; stqFreed_i = 3'd1; alFreed_i = 3'd4;
    at_mid();
    chk("flush_stall", 32'(stall_o), 0);
    chk("flush_fire", 32'(dispatchFire_o), 0);
    next_cyc();
    flush_i = 1'b0; iqFreed_i = '0; ldqFreed_i = '0; stqFreed_i = '0; alFreed_i = '0;
    bundleValid_i = 1'b0; isLoad_i = 4'h0;
    at_mid();
    chk("post_flush_iq", 32'(iqFree_o), 32);
    chk("post_flush_ldq", 32'(ldqFree_o), 16);
    chk("post_flush_stq", 32'(stqFree_o), 16);
    chk("post_flush_al", 32'(alFree_o), 128);
    chk("post_flush_sc", stallCycles_o, 2);
    next_cyc();

    // Clamp: dispatch 1 and return 4 at iqFree=31.
    bundleValid_i = 1'b1; laneActive_i = 4'b0001;
    next_cyc();
    iqFreed_i = 3'd4;
    at_mid();
    chk("clamp_pre_iq", 32'(iqFree_o), 31);
    chk("clamp_fire", 32'(dispatchFire_o), 1);
    next_cyc();
    iqFreed_i = 3'd0; bundleValid_i = 1'b0;
    at_mid();
    chk("clamp_iq", 32'(iqFree_o), 32);
    chk("clamp_al", 32'(alFree_o), 126);
    next_cyc();

    // Reset while a bundle is stalled on the issue queue.
    bundleValid_i = 1'b1; laneActive_i = 4'hF;
    repeat (8) next_cyc();
    at_mid();
    chk("pre_rst_stall", 32'(stall_o), 1);
    next_cyc();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    at_mid();
    chk("rst_mid_fire", 32'(dispatchFire_o), 1);
    chk("rst_mid_iq", 32'(iqFree_o), 32);
    chk("rst_mid_sc", stallCycles_o, 0);
    next_cyc();
    bundleValid_i = 1'b0;
    at_mid();
    chk("rst_mid_after_iq", 32'(iqFree_o), 28);
    next_cyc();

    chk_en = 1'b0;
    $display("protocol over-return events observed: %0d", n_proto);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
